data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Handshaked data-memory responder for the RV32I load/store path. It accepts one load or store request at a time over a valid/ready request channel and performs byte, halfword or word access on an internal word-organised RAM. It inserts a programmable number of wait states and returns read data or an error flag over a valid/ready response channel. It is the memory-side endpoint the multi-cycle and pipelined cores use in place of the zero-latency data memory.

## Interface
- DEPTH_WORDS, 256, number of 32-bit RAM words; valid word index is addr[31:2] < DEPTH_WORDS
- WAIT_STATES, 2, cycles spent in WAIT before commit (0 allowed)
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock, reset synchronous active-high
- req_valid  input  1  request present
- req_ready  output  1  responder can accept (high only in IDLE)
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data (low bits used for SB/SH)
- req_funct3  input  3  RV32I funct3: loads 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores 0 SB, 1 SH, 2 SW
- resp_valid  output  1  response present
- resp_ready  input  1  requester accepts response
- resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors
- resp_err  output  1  request was misaligned, out of range or had an illegal funct3

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid & req_ready, capture write, addr, wdata and funct3, and clear the wait counter. Next state is WAIT if WAIT_STATES>0, otherwise commit immediately and go to RESP.
- WAIT: counter increments each cycle. When count==WAIT_STATES-1, commit and go to RESP.
- Commit, a single edge:
  - Stores: write enabled lanes of RAM[addr[31:2]].
  - Loads: register the extended data into resp_rdata.
  - resp_err is registered at the same edge.
- RESP: resp_valid=1; resp_rdata and resp_err are held stable. On resp_ready, go to IDLE. While resp_ready=0, stay in RESP.
- Error detection, evaluated on captured fields:
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
  - Out of range: addr[31:2] ≥ DEPTH_WORDS.
  - Illegal funct3: load funct3 ∈ {3,6,7}; store funct3 ≥ 3.
  - On error: no RAM write, resp_rdata=0, resp_err=1.
- Store lanes:
  - SB writes byte lane addr[1:0] with wdata[7:0].
  - SH writes lanes {2·addr[1]+1, 2·addr[1]} with wdata[15:0].
  - SW writes all four lanes.
  - Other lanes are unchanged.
- Load extraction:
  - LB/LBU select byte addr[1:0]; LH/LHU select halfword addr[1].
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
  - LW returns the full word.
- Successful store response: resp_rdata=0, resp_err=0.
- Requests presented outside IDLE are ignored (req_ready=0). The requester must hold them.

## Timing
- Reset values: state=IDLE, req_ready=1 (combinational from state), resp_valid=0, resp_rdata=0, resp_err=0, counter=0. RAM contents are not cleared by reset.
- Acceptance at edge T0 → resp_valid high during the cycle after edge T0+WAIT_STATES.
- With WAIT_STATES=0, resp_valid is high in the cycle right after acceptance.
- Minimum request-to-request spacing: WAIT_STATES+2 cycles (the RESP cycle plus the IDLE accept cycle).
- resp_ready high in the first RESP cycle → IDLE next cycle. Back-pressure extends RESP indefinitely with outputs frozen.
- Reset has priority over every transition. Reset asserted on the commit edge suppresses the store write. Reset during WAIT or RESP drops the transaction with no response.
- req_valid together with reset: ignored. The first accept is possible on the edge after reset deasserts.
- Store→load of the same address: the load observes the stored value, since the write commits before the next request can be accepted.

## Test plan
- Reset, then SW addr 0x10 data 0xDEADBEEF; LW 0x10 → resp_rdata=0xDEADBEEF, resp_err=0. resp_valid rises exactly WAIT_STATES+1 cycles after the accept edge.
- SB 0x13 data 0x80, then LB 0x13 → 0xFFFFFF80 and LBU 0x13 → 0x00000080. LW 0x10 → 0x80ADBEEF.
- SH 0x12 data 0x1234, then LH 0x12 → 0x00001234. LH 0x11 → resp_err=1, rdata=0. SW 0x11 → resp_err=1 and the word at 0x10 is unchanged.
- Address 4·DEPTH_WORDS: LW → resp_err=1. Load funct3=3 → resp_err=1.
- resp_ready held low 5 cycles in RESP → resp_valid and rdata stable, req_ready=0. A new req_valid during those cycles is not accepted.
- Reset pulsed during WAIT of SW 0x20 data 0x55 → no response and req_ready=1 after reset. A later LW 0x20 returns the prior contents. Repeat the run with WAIT_STATES=0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Handshaked RV32I data-memory responder: one load/store at a time over valid/ready,
// byte/half/word access to a word-organised RAM, programmable wait states before commit.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  logic        cap_write;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [2:0]  cap_funct3;

  logic [31:0] mem [DEPTH_WORDS];

  logic        op_write;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [2:0]  op_funct3;

  logic             accept;
  logic             commit;
  logic             misaligned;
  logic             out_of_range;
  logic             bad_funct3;
  logic             op_err;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      load_data;
  logic [3:0]       wr_mask;
  logic [31:0]      wr_data;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;

  // With zero wait states the commit happens on the accept edge, so it must see the live request.
  always_comb begin
    if (state == S_IDLE) begin
      op_write  = req_write;
      op_addr   = req_addr;
      op_wdata  = req_wdata;
      op_funct3 = req_funct3;
    end else begin
      op_write  = cap_write;
      op_addr   = cap_addr;
      op_wdata  = cap_wdata;
      op_funct3 = cap_funct3;
    end
  end

  assign commit = !reset && ((accept && (WAIT_STATES == 0)) ||
                             ((state == S_WAIT) && (wait_cnt == CNT_LAST)));

  always_comb begin
    misaligned   = ((op_funct3[1:0] == 2'b01) && op_addr[0]) ||
                   ((op_funct3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
    out_of_range = {2'b00, op_addr[31:2]} >= 32'(DEPTH_WORDS);
    if (op_write) begin
      bad_funct3 = (op_funct3 >= 3'd3);
    end else begin
      bad_funct3 = (op_funct3 == 3'd3) || (op_funct3 == 3'd6) || (op_funct3 == 3'd7);
    end
    op_err = misaligned || out_of_range || bad_funct3;
  end

  assign word_idx = op_addr[IDX_W+1:2];
  assign rd_word  = mem[word_idx];

  always_comb begin
    case (op_addr[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (op_funct3)
      3'd0:    load_data = {{24{rd_byte[7]}}, rd_byte};
      3'd1:    load_data = {{16{rd_half[15]}}, rd_half};
      3'd2:    load_data = rd_word;
      3'd4:    load_data = {24'h000000, rd_byte};
      3'd5:    load_data = {16'h0000, rd_half};
      default: load_data = '0;
    endcase
    if (op_err) begin
      load_data = '0;
    end
  end

  // Store data is replicated across lanes so the lane mask alone picks the destination bytes.
  always_comb begin
    wr_mask = '0;
    wr_data = op_wdata;
    case (op_funct3[1:0])
      2'b00: begin
        wr_mask = 4'b0001 << op_addr[1:0];
        wr_data = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        wr_mask = op_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{op_wdata[15:0]}};
      end
      2'b10:   wr_mask = '1;
      default: wr_mask = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit && op_write && !op_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr_mask[i]) begin
          mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cap_write  <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_funct3 <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cap_write  <= req_write;
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
            cap_funct3 <= req_funct3;
            wait_cnt   <= '0;
            state      <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == CNT_LAST) begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (commit) begin
        resp_valid <= 1'b1;
        resp_rdata <= op_write ? '0 : load_data;
        resp_err   <= op_err;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (2 and 0 wait states) checked every cycle
// against a byte-addressed transaction model, plus literal expectations per transaction.
module tb_data_mem_responder;

  localparam int DEPTH = 256;

  logic              clk = 1'b0;
  logic [1:0]        reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_write;
  logic [1:0][31:0]  req_addr;
  logic [1:0][31:0]  req_wdata;
  logic [1:0][2:0]   req_funct3;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [1:0][31:0]  resp_rdata;
  logic [1:0]        resp_err;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut_w2 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_funct3(req_funct3[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_w0 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_funct3(req_funct3[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit armed  = 1'b0;

  // Transaction-level model: byte-addressed memory, one outstanding request per instance.
  logic [7:0]       mb [2][4*DEPTH];
  bit               pend [2];
  bit               committed [2];
  int               t0 [2];
  bit               m_wr [2];
  logic [31:0]      m_addr [2];
  logic [31:0]      m_wdata [2];
  logic [2:0]       m_f3 [2];
  logic [31:0]      exp_rd [2];
  bit               exp_er [2];

  function automatic int ws(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic bit model_err(input bit wr, input logic [31:0] a, input logic [2:0] f3);
    int  size;
    bit  illegal;
    size    = 1 << int'(f3[1:0]);
    illegal = wr ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    return illegal || ((a % 32'(size)) != 0) || ((a >> 2) >= 32'(DEPTH));
  endfunction

  task automatic model_commit(input int d);
    bit          e;
    int          size;
    logic [31:0] v;
    e    = model_err(m_wr[d], m_addr[d], m_f3[d]);
    size = 1 << int'(m_f3[d][1:0]);
    v    = '0;
    exp_er[d] = e;
    exp_rd[d] = '0;
    if (!e) begin
      if (m_wr[d]) begin
        for (int i = 0; i < size; i++) mb[d][m_addr[d] + 32'(i)] = 8'(m_wdata[d] >> (8*i));
      end else begin
        for (int i = size - 1; i >= 0; i--) v = (v << 8) | 32'(mb[d][m_addr[d] + 32'(i)]);
        if (!m_f3[d][2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
        exp_rd[d] = v;
      end
    end
    committed[d] = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (reset[d]) begin
        pend[d] = 1'b0;
      end else if (pend[d]) begin
        if (!committed[d]) begin
          if (cyc == t0[d] + ws(d)) model_commit(d);
        end else if (resp_ready[d]) begin
          pend[d] = 1'b0;
        end
      end else if (req_valid[d]) begin
        m_wr[d] = req_write[d];  m_addr[d] = req_addr[d];
        m_wdata[d] = req_wdata[d]; m_f3[d] = req_funct3[d];
        t0[d] = cyc; pend[d] = 1'b1; committed[d] = 1'b0;
        if (ws(d) == 0) model_commit(d);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        bit ev;
        ev = pend[d] && committed[d];
        check($sformatf("d%0d resp_valid", d), 32'(resp_valid[d]), 32'(ev));
        check($sformatf("d%0d req_ready", d), 32'(req_ready[d]), 32'(!pend[d]));
        if (ev) begin
          check($sformatf("d%0d resp_rdata", d), resp_rdata[d], exp_rd[d]);
          check($sformatf("d%0d resp_err", d), 32'(resp_err[d]), 32'(exp_er[d]));
        end
      end
    end
  end

  task automatic xact(input int d, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int hold, input logic [31:0] lit_rd,
                      input bit lit_er, input string tag);
    int k;
    req_valid[d] = 1'b1; req_write[d] = wr; req_funct3[d] = f3;
    req_addr[d] = a; req_wdata[d] = wd;
    @(posedge clk); #2;
    req_valid[d] = 1'b0;
    k = 0;
    while (!resp_valid[d] && k < 20) begin
      @(posedge clk); #2;
      k++;
    end
    check($sformatf("d%0d %s latency", d, tag), 32'(k), 32'(ws(d)));
    if (hold > 0) begin
      req_valid[d] = 1'b1; req_write[d] = 1'b1; req_funct3[d] = 3'd2;
      req_addr[d] = 32'h40; req_wdata[d] = 32'hCAFE_F00D;
      repeat (hold) begin
        @(posedge clk); #2;
      end
    end
    check($sformatf("d%0d %s rdata", d, tag), resp_rdata[d], lit_rd);
    check($sformatf("d%0d %s err", d, tag), 32'(resp_err[d]), 32'(lit_er));
    resp_ready[d] = 1'b1;
    req_valid[d]  = 1'b0;
    @(posedge clk); #2;
    resp_ready[d] = 1'b0;
  endtask

  // Store accepted, then reset lands n edges later together with a request that must be ignored.
  task automatic rst_mid(input int d, input logic [31:0] a, input logic [31:0] wd, input int n,
                         input string tag);
    req_valid[d] = 1'b1; req_write[d] = 1'b1; req_funct3[d] = 3'd2;
    req_addr[d] = a; req_wdata[d] = wd;
    @(posedge clk); #2;
    req_valid[d] = 1'b0;
    repeat (n - 1) begin
      @(posedge clk); #2;
    end
    reset[d] = 1'b1;
    req_valid[d] = 1'b1; req_wdata[d] = 32'h99;
    @(posedge clk); #2;
    reset[d] = 1'b0;
    req_valid[d] = 1'b0;
    check($sformatf("d%0d %s ready after reset", d, tag), 32'(req_ready[d]), 32'd1);
    repeat (3) begin
      @(posedge clk); #2;
    end
    check($sformatf("d%0d %s no response", d, tag), 32'(resp_valid[d]), 32'd0);
  endtask

  task automatic run_suite(input int d);
    xact(d, 1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0, 32'h0, 0, "sw10");
    xact(d, 0, 3'd2, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 0, "lw10a");
    xact(d, 1, 3'd0, 32'h13, 32'h80, 0, 32'h0, 0, "sb13");
    xact(d, 0, 3'd0, 32'h13, 32'h0, 0, 32'hFFFF_FF80, 0, "lb13");
    xact(d, 0, 3'd4, 32'h13, 32'h0, 0, 32'h0000_0080, 0, "lbu13");
    xact(d, 0, 3'd2, 32'h10, 32'h0, 0, 32'h80AD_BEEF, 0, "lw10b");
    xact(d, 1, 3'd1, 32'h12, 32'h1234, 0, 32'h0, 0, "sh12");
    xact(d, 0, 3'd1, 32'h12, 32'h0, 0, 32'h0000_1234, 0, "lh12");
    xact(d, 0, 3'd1, 32'h11, 32'h0, 0, 32'h0, 1, "lh11");
    xact(d, 1, 3'd2, 32'h11, 32'hFFFF_FFFF, 0, 32'h0, 1, "sw11");
    xact(d, 0, 3'd2, 32'h10, 32'h0, 0, 32'h1234_BEEF, 0, "lw10c");
    xact(d, 0, 3'd2, 32'(4*DEPTH), 32'h0, 0, 32'h0, 1, "lw_oor");
    xact(d, 0, 3'd3, 32'h10, 32'h0, 0, 32'h0, 1, "ld_f3_3");
    xact(d, 0, 3'd6, 32'h10, 32'h0, 0, 32'h0, 1, "ld_f3_6");
    xact(d, 1, 3'd3, 32'h10, 32'h0, 0, 32'h0, 1, "st_f3_3");
    xact(d, 1, 3'd1, 32'h16, 32'h0000_8001, 0, 32'h0, 0, "sh16");
    xact(d, 0, 3'd1, 32'h16, 32'h0, 0, 32'hFFFF_8001, 0, "lh16");
    xact(d, 0, 3'd5, 32'h16, 32'h0, 0, 32'h0000_8001, 0, "lhu16");
    xact(d, 1, 3'd2, 32'(4*DEPTH-4), 32'h0BAD_F00D, 0, 32'h0, 0, "sw_last");
    xact(d, 0, 3'd2, 32'(4*DEPTH-4), 32'h0, 0, 32'h0BAD_F00D, 0, "lw_last");
    xact(d, 0, 3'd2, 32'h10, 32'h0, 5, 32'h1234_BEEF, 0, "lw10_bp");
    xact(d, 1, 3'd2, 32'h20, 32'h1122_3344, 0, 32'h0, 0, "sw20");
    rst_mid(d, 32'h20, 32'h55, 1, "rst1");
    xact(d, 0, 3'd2, 32'h20, 32'h0, 0, (d == 0) ? 32'h1122_3344 : 32'h0000_0055, 0, "lw20");
    xact(d, 1, 3'd2, 32'h24, 32'hAABB_CCDD, 0, 32'h0, 0, "sw24");
    rst_mid(d, 32'h24, 32'h66, 2, "rst2");
    xact(d, 0, 3'd2, 32'h24, 32'h0, 0, (d == 0) ? 32'hAABB_CCDD : 32'h0000_0066, 0, "lw24");
  endtask

  initial begin
    reset = 2'b11; req_valid = '0; req_write = '0; req_addr = '0;
    req_wdata = '0; req_funct3 = '0; resp_ready = '0;
    repeat (3) @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d reset resp_valid", d), 32'(resp_valid[d]), 32'd0);
      check($sformatf("d%0d reset resp_rdata", d), resp_rdata[d], 32'd0);
      check($sformatf("d%0d reset resp_err", d), 32'(resp_err[d]), 32'd0);
      check($sformatf("d%0d reset req_ready", d), 32'(req_ready[d]), 32'd1);
    end
    reset = 2'b00;
    armed = 1'b1;
    run_suite(0);
    run_suite(1);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
